// File: rtl/eqed_inject_ctrl.sv
// rtl/eqed_inject_ctrl.sv - E-QED bit-flip injection controller with signature MISR
//
// Purpose:
//   Drives the one-hot select lines of the inverting muxes placed on a design
//   module's flip-flops. Injection is limited to a programmable cycle window
//   and a maximum number of injections per run. The observed outputs are
//   compacted into a MISR for a fixed number of cycles, after which the block
//   freezes so that the formal tool can compare the signature against the
//   golden value.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-low reset (0 = reset)
//   sel          in   binary flip-flop select; codes >= NUM_FF mean "no injection"
//   inj_req      in   request an injection this cycle
//   win_lo       in   first cycle in which injection is allowed (inclusive)
//   win_hi       in   last cycle in which injection is allowed (inclusive)
//   obs_data     in   observed design outputs folded into the MISR
//   eqed_sel     out  one-hot flip select, combinational
//   inj_fire     out  OR of eqed_sel
//   inj_cnt      out  number of injections performed this run
//   inj_idx      out  sel value at the first injection
//   inj_cycle    out  cycle_count at the first injection
//   cycle_count  out  run cycle number, starts at 1
//   misr         out  signature register
//   window_done  out  high once the capture window has closed

module eqed_inject_ctrl #(
  parameter int                NUM_FF    = 8,
  parameter int                SEL_W     = 4,
  parameter int                CNT_W     = 10,
  parameter int                MAX_INJ   = 1,
  parameter int                MISR_W    = 6,
  parameter logic [MISR_W-1:0] MISR_POLY = 6'b110000,
  parameter int                DATA_W    = 3,
  parameter int                CAPTURE   = 5,
  // A zero-injection build still needs a 1-bit counter port.
  localparam int               INJ_W     = (MAX_INJ > 0) ? $clog2(MAX_INJ + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  sel,
  input  logic              inj_req,
  input  logic [CNT_W-1:0]  win_lo,
  input  logic [CNT_W-1:0]  win_hi,
  input  logic [DATA_W-1:0] obs_data,
  output logic [NUM_FF-1:0] eqed_sel,
  output logic              inj_fire,
  output logic [INJ_W-1:0]  inj_cnt,
  output logic [SEL_W-1:0]  inj_idx,
  output logic [CNT_W-1:0]  inj_cycle,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [MISR_W-1:0] misr,
  output logic              window_done
);

  localparam logic [SEL_W-1:0] NUM_FF_C  = SEL_W'(NUM_FF);
  localparam logic [INJ_W-1:0] MAX_INJ_C = INJ_W'(MAX_INJ);
  localparam logic [CNT_W-1:0] CAPTURE_C = CNT_W'(CAPTURE);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                elig;
  logic                cnt_ok;
  logic                in_window;
  logic                fb;
  logic [MISR_W-1:0]   misr_nxt;

  // State register plus datapath registers. Reset wins over everything and
  // restarts the run at cycle 1 with the MISR seeded to 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_RUN;
      cycle_count <= CNT_W'(1);
      misr        <= MISR_W'(1);
      inj_cnt     <= '0;
      inj_idx     <= '0;
      inj_cycle   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN) begin
        // Increments on the RUN->DONE edge too, so DONE holds CAPTURE+1.
        cycle_count <= cycle_count + CNT_W'(1);
        misr        <= misr_nxt;
        if (inj_fire) begin
          inj_cnt <= inj_cnt + INJ_W'(1);
          // Only the first injection of a run is recorded.
          if (inj_cnt == '0) begin
            inj_idx   <= sel;
            inj_cycle <= cycle_count;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    eqed_sel  = '0;
    cnt_ok    = 1'b0;
    in_window = 1'b0;
    elig      = 1'b0;
    fb        = 1'b0;
    misr_nxt  = misr;

    case (state)
      S_RUN: begin
        if (cycle_count == CAPTURE_C) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase

    // MAX_INJ == 0 must block injection regardless of the counter value.
    cnt_ok    = (MAX_INJ > 0) && (inj_cnt < MAX_INJ_C);
    // An inverted window (win_lo > win_hi) can never satisfy both bounds.
    in_window = (cycle_count >= win_lo) && (cycle_count <= win_hi);
    // Eligibility uses the current state, so a request on the final RUN
    // cycle is still honoured. rst gates the select off during reset.
    elig      = rst && (state == S_RUN) && inj_req && cnt_ok && in_window &&
                (sel < NUM_FF_C);

    if (elig) begin
      eqed_sel = NUM_FF'(1) << sel;
    end

    fb       = ^(misr & MISR_POLY);
    misr_nxt = {misr[MISR_W-2:0], fb} ^ MISR_W'(obs_data);
  end

  assign inj_fire    = |eqed_sel;
  assign window_done = (state == S_DONE);

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// tb/tb_eqed_inject_ctrl.sv - self-checking bench for eqed_inject_ctrl

module tb_eqed_inject_ctrl;

  localparam int CAPTURE = 5;
  localparam int POLY    = 6'b110000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sel = '0;
  logic       inj_req = 1'b0;
  logic [9:0] win_lo = '0;
  logic [9:0] win_hi = '0;
  logic [2:0] obs_data = '0;

  logic [7:0] eqed_sel1, eqed_sel2;
  logic       inj_fire1, inj_fire2;
  logic [0:0] inj_cnt1;
  logic [1:0] inj_cnt2;
  logic [3:0] inj_idx1, inj_idx2;
  logic [9:0] inj_cycle1, inj_cycle2;
  logic [9:0] cycle_count1, cycle_count2;
  logic [5:0] misr1, misr2;
  logic       window_done1, window_done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eqed_inject_ctrl #(.MAX_INJ(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .inj_req(inj_req),
    .win_lo(win_lo), .win_hi(win_hi), .obs_data(obs_data),
    .eqed_sel(eqed_sel1), .inj_fire(inj_fire1), .inj_cnt(inj_cnt1),
    .inj_idx(inj_idx1), .inj_cycle(inj_cycle1), .cycle_count(cycle_count1),
    .misr(misr1), .window_done(window_done1)
  );

  eqed_inject_ctrl #(.MAX_INJ(2)) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .inj_req(inj_req),
    .win_lo(win_lo), .win_hi(win_hi), .obs_data(obs_data),
    .eqed_sel(eqed_sel2), .inj_fire(inj_fire2), .inj_cnt(inj_cnt2),
    .inj_idx(inj_idx2), .inj_cycle(inj_cycle2), .cycle_count(cycle_count2),
    .misr(misr2), .window_done(window_done2)
  );

  // Reference model: one run record per instance, plain integers.
  int max_inj [2] = '{1, 2};
  int m_cyc   [2];
  int m_misr  [2];
  int m_cnt   [2];
  int m_idx   [2];
  int m_icyc  [2];
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k + 1, act, exp, $time);
    end
  endtask

  function automatic int misr_step(input int m, input int d);
    int fb = 0;
    for (int i = 0; i < 6; i++)
      if ((POLY >> i) & 1) fb ^= (m >> i) & 1;
    return (((m << 1) | fb) & 63) ^ d;
  endfunction

  function automatic int exp_sel(input int k);
    if (rst && m_cyc[k] <= CAPTURE && inj_req && m_cnt[k] < max_inj[k] &&
        int'(win_lo) <= m_cyc[k] && m_cyc[k] <= int'(win_hi) && int'(sel) < 8)
      return 1 << sel;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      model_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_cyc[k] = 1; m_misr[k] = 1; m_cnt[k] = 0; m_idx[k] = 0; m_icyc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k] <= CAPTURE) begin
          if (exp_sel(k) != 0) begin
            if (m_cnt[k] == 0) begin
              m_idx[k]  = int'(sel);
              m_icyc[k] = m_cyc[k];
            end
            m_cnt[k]++;
          end
          m_misr[k] = misr_step(m_misr[k], int'(obs_data));
          m_cyc[k]++;
        end
      end
    end
  end

  // Compare process: every falling edge once the model is initialised.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("eqed_sel",    0, int'(eqed_sel1),    exp_sel(0));
      chk("inj_fire",    0, int'(inj_fire1),    int'(exp_sel(0) != 0));
      chk("inj_cnt",     0, int'(inj_cnt1),     m_cnt[0]);
      chk("inj_idx",     0, int'(inj_idx1),     m_idx[0]);
      chk("inj_cycle",   0, int'(inj_cycle1),   m_icyc[0]);
      chk("cycle_count", 0, int'(cycle_count1), m_cyc[0]);
      chk("misr",        0, int'(misr1),        m_misr[0]);
      chk("window_done", 0, int'(window_done1), int'(m_cyc[0] > CAPTURE));
      chk("eqed_sel",    1, int'(eqed_sel2),    exp_sel(1));
      chk("inj_fire",    1, int'(inj_fire2),    int'(exp_sel(1) != 0));
      chk("inj_cnt",     1, int'(inj_cnt2),     m_cnt[1]);
      chk("inj_idx",     1, int'(inj_idx2),     m_idx[1]);
      chk("inj_cycle",   1, int'(inj_cycle2),   m_icyc[1]);
      chk("cycle_count", 1, int'(cycle_count2), m_cyc[1]);
      chk("misr",        1, int'(misr2),        m_misr[1]);
      chk("window_done", 1, int'(window_done2), int'(m_cyc[1] > CAPTURE));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in cycle 1 with reset released.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // MISR with zero input: 2, 4, 8, 10, 21 then frozen.
    obs_data = 3'd0; inj_req = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("lit_zero_misr",  0, int'(misr1), 6'h21);
    chk("lit_zero_cycle", 0, int'(cycle_count1), 6);
    chk("lit_zero_done",  0, int'(window_done1), 1);
    repeat (10) tick();
    chk("lit_zero_hold",  0, int'(misr1), 6'h21);
    chk("lit_zero_cyc_hold", 0, int'(cycle_count1), 6);

    // MISR with constant input 001.
    obs_data = 3'b001;
    do_reset();
    repeat (5) tick();
    chk("lit_const_misr",  0, int'(misr1), 6'h3E);
    chk("lit_const_cycle", 0, int'(cycle_count1), 6);

    // Single injection at cycle 3, sel 5.
    obs_data = 3'd0; win_lo = 10'd2; win_hi = 10'd4; sel = 4'd5;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      inj_req = (c == 3);
      #1;
      chk("lit_single_sel", 0, int'(eqed_sel1), (c == 3) ? 8'h20 : 8'h00);
      tick();
    end
    inj_req = 1'b0;
    chk("lit_single_cnt",  0, int'(inj_cnt1), 1);
    chk("lit_single_idx",  0, int'(inj_idx1), 5);
    chk("lit_single_cyc",  0, int'(inj_cycle1), 3);

    // Window and count limits with a request every cycle.
    sel = 4'd0; inj_req = 1'b1;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("lit_limit_sel1", 0, int'(eqed_sel1), (c == 2) ? 8'h01 : 8'h00);
      chk("lit_limit_sel2", 1, int'(eqed_sel2), (c == 2 || c == 3) ? 8'h01 : 8'h00);
      tick();
    end
    chk("lit_limit_cnt1", 0, int'(inj_cnt1), 1);
    chk("lit_limit_cnt2", 1, int'(inj_cnt2), 2);
    chk("lit_limit_cyc2", 1, int'(inj_cycle2), 2);

    // Out-of-range select, then an inverted window.
    sel = 4'd8; win_lo = 10'd1; win_hi = 10'd5;
    do_reset();
    repeat (6) tick();
    chk("lit_oor_cnt", 1, int'(inj_cnt2), 0);
    sel = 4'd1; win_lo = 10'd4; win_hi = 10'd3;
    do_reset();
    repeat (6) tick();
    chk("lit_empty_cnt", 1, int'(inj_cnt2), 0);

    // Reset asserted in cycle 3 with an eligible request.
    sel = 4'd2; win_lo = 10'd1; win_hi = 10'd10;
    do_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("lit_rst_sel",  0, int'(eqed_sel1), 0);
    chk("lit_rst_fire", 1, int'(inj_fire2), 0);
    tick();
    rst = 1'b1;
    chk("lit_rst_cycle", 0, int'(cycle_count1), 1);
    chk("lit_rst_misr",  0, int'(misr1), 1);
    chk("lit_rst_cnt",   1, int'(inj_cnt2), 0);
    chk("lit_rst_done",  0, int'(window_done1), 0);
    inj_req = 1'b0;

    // Randomised runs checked by the model.
    for (int r = 0; r < 60; r++) begin
      win_lo = 10'($urandom_range(0, 7));
      win_hi = 10'($urandom_range(0, 7));
      do_reset();
      for (int c = 0; c < 9; c++) begin
        sel      = 4'($urandom_range(0, 15));
        inj_req  = ($urandom_range(0, 2) != 0);
        obs_data = 3'($urandom);
        rst      = ($urandom_range(0, 24) != 0);
        tick();
      end
      rst = 1'b1;
    end

    inj_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
